// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Fetch-stage branch predictor. It uses a branch history table (BHT) of 2-bit
//   saturating counters, indexed by pc[IDX_W+1:2]. Fetch looks up a PC and gets
//   a combinational taken/not-taken answer. EX later trains the table with the
//   resolved outcome. Two saturating statistics counters record how many
//   branches resolved and how many of them were mispredicted.
//
//   Optional feature, selected by the macro BP_BTB_EN:
//     When defined, a direct-mapped branch target buffer (valid, tag, target)
//     shares the BHT index. A lookup then predicts taken only on a tag hit, and
//     it supplies the stored target. When undefined there is no BTB storage,
//     and predict_hit and predict_target are tied to zero.
//
// Ports
//   clk             in   1   rising-edge clock
//   rst             in   1   asynchronous, active-low reset
//   lookup_valid    in   1   fetch presents lookup_pc this cycle
//   lookup_pc       in   32  fetch PC
//   predict_taken   out  1   predicted taken (combinational)
//   predict_hit     out  1   BTB hit (0 without BP_BTB_EN)
//   predict_target  out  32  predicted target (0 without BP_BTB_EN or on miss)
//   update_valid    in   1   a conditional branch / JALR resolved this cycle
//   update_pc       in   32  PC of the resolved instruction
//   update_taken    in   1   actual outcome
//   update_pred     in   1   prediction that was made for it
//   update_target   in   32  actual target address
//   branch_cnt      out  32  resolved branches (saturating)
//   mispred_cnt     out  32  mispredicted branches (saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        predict_taken,
  output logic        predict_hit,
  output logic [31:0] predict_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic        update_pred,
  input  logic [31:0] update_target,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  ctr_t             bht [ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;

  // Bits [1:0] are ignored, so misaligned PCs index the table as-is.
  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign update_idx = update_pc[IDX_W+1:2];

  // ---------------------------------------------------------------------------
  // BHT training. Only the indexed entry moves. The async reset puts every
  // entry back to weakly-not-taken at once and discards any update in flight.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every reader
  // in this cycle sees the pre-edge value. Because of this, a same-cycle lookup
  // returns the old counter with no bypass path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= WNT;
    end else if (update_valid) begin
      if (update_taken) begin
        if (bht[update_idx] != ST) bht[update_idx] <= ctr_t'(bht[update_idx] + 2'd1);
      end else begin
        if (bht[update_idx] != SNT) bht[update_idx] <= ctr_t'(bht[update_idx] - 2'd1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics. Both counters stick at all-ones instead of wrapping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (update_valid) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
      if ((update_taken ^ update_pred) && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

`ifdef BP_BTB_EN
  // ---------------------------------------------------------------------------
  // BTB. Only taken branches allocate, and they always overwrite the slot.
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [31:0]        btb_target [ENTRIES];
  logic [TAG_W-1:0]   lookup_tag;
  logic [TAG_W-1:0]   update_tag;
  logic               unused_pc_bits;

  assign lookup_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign update_tag = update_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+TAG_W+2], lookup_pc[1:0],
                            update_pc[31:IDX_W+TAG_W+2], update_pc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_valid <= '0;
    end else if (update_valid && update_taken) begin
      btb_valid[update_idx] <= 1'b1;
    end
  end

  // NOTE: only the valid bits need a reset. Tag and target are never read
  // while their valid bit is clear, so they stay as plain storage without a
  // reset and can map to RAM.
  always_ff @(posedge clk) begin
    if (rst && update_valid && update_taken) begin
      btb_tag[update_idx]    <= update_tag;
      btb_target[update_idx] <= update_target;
    end
  end

  // NOTE: every output gets a default first, so no path through this block
  // can infer a latch.
  always_comb begin
    predict_hit    = 1'b0;
    predict_taken  = 1'b0;
    predict_target = 32'h0;
    if (lookup_valid && btb_valid[lookup_idx] && (btb_tag[lookup_idx] == lookup_tag)) begin
      predict_hit    = 1'b1;
      predict_taken  = bht[lookup_idx][1];
      predict_target = btb_target[lookup_idx];
    end
  end
`else
  logic unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                            update_pc[31:IDX_W+2], update_pc[1:0], update_target};

  // Without a BTB, decode computes the target and this block only gives the
  // direction.
  always_comb begin
    predict_hit    = 1'b0;
    predict_target = 32'h0;
    predict_taken  = lookup_valid & bht[lookup_idx][1];
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Self-checking bench for branch_predictor. Each cycle a reference model
//   computes the expected outputs, using the table state from before the edge.
//   These are pushed to a scoreboard queue when the stimulus is driven. They
//   are popped and compared on the falling edge. The model follows BP_BTB_EN
//   in the same way as the design.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int IDX_W   = 6;
  localparam int TAG_W   = 8;
  localparam int ENTRIES = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic        predict_hit;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_pred;
  logic [31:0] update_target;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  branch_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_valid   (lookup_valid),
    .lookup_pc      (lookup_pc),
    .predict_taken  (predict_taken),
    .predict_hit    (predict_hit),
    .predict_target (predict_target),
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_pred    (update_pred),
    .update_target  (update_target),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        taken;
    logic        hit;
    logic [31:0] target;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_bht    [ENTRIES];
  bit          m_valid  [ENTRIES];
  logic [31:0] m_pc     [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    logic [IDX_W-1:0] idx;
    idx = pc[IDX_W+1:2];
    return int'(idx);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
    return pc[IDX_W+TAG_W+1:IDX_W+2];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_bht[i]   = 1;
      m_valid[i] = 1'b0;
    end
    m_bcnt = '0;
    m_mcnt = '0;
  endtask

  // One clock cycle: drive the inputs, queue the expected outputs, compare them
  // on the falling edge, then let the model take the update at the rising edge.
  task automatic cycle(input string name, input bit lv, input logic [31:0] lpc,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input bit up, input logic [31:0] utgt);
    exp_t e;
    exp_t got;
    int   li;
    int   ui;
    lookup_valid  = lv;
    lookup_pc     = lpc;
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_pred   = up;
    update_target = utgt;

    li     = idx_of(lpc);
    e.name = name;
`ifdef BP_BTB_EN
    e.hit    = lv && m_valid[li] && (tag_of(m_pc[li]) == tag_of(lpc));
    e.taken  = e.hit && (m_bht[li] >= 2);
    e.target = e.hit ? m_target[li] : 32'h0;
`else
    e.hit    = 1'b0;
    e.taken  = lv && (m_bht[li] >= 2);
    e.target = 32'h0;
`endif
    e.bcnt = m_bcnt;
    e.mcnt = m_mcnt;
    sb.push_back(e);

    @(negedge clk);
    got = sb.pop_front();
    check({got.name, ".taken"},  {31'b0, predict_taken}, {31'b0, got.taken});
    check({got.name, ".hit"},    {31'b0, predict_hit},   {31'b0, got.hit});
    check({got.name, ".target"}, predict_target,         got.target);
    check({got.name, ".bcnt"},   branch_cnt,             got.bcnt);
    check({got.name, ".mcnt"},   mispred_cnt,            got.mcnt);

    @(posedge clk);
    if (uv) begin
      ui = idx_of(upc);
      if (ut && m_bht[ui] < 3) m_bht[ui]++;
      if (!ut && m_bht[ui] > 0) m_bht[ui]--;
      if (ut) begin
        m_valid[ui]  = 1'b1;
        m_pc[ui]     = upc;
        m_target[ui] = utgt;
      end
      if (m_bcnt != '1) m_bcnt++;
      if ((ut ^ up) && m_mcnt != '1) m_mcnt++;
    end
    #1;
    update_valid = 1'b0;
    lookup_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    lookup_valid  = 1'b0;
    lookup_pc     = '0;
    update_valid  = 1'b0;
    update_pc     = '0;
    update_taken  = 1'b0;
    update_pred   = 1'b0;
    update_target = '0;
    model_reset();
    #12 rst = 1'b1;
    @(posedge clk);
    #1;

    // Out of reset, every counter is 01 and both stats are zero.
    cycle("rst_lookup", 1, 32'h40, 0, 32'h0, 0, 0, 32'h0);
    check("rst_bcnt_zero", branch_cnt, 32'd0);

    // Two taken updates that were mispredicted move the counter 01 -> 10 -> 11.
    cycle("train_t0", 1, 32'h40, 1, 32'h40, 1, 0, 32'h1000);
    cycle("train_t1", 1, 32'h40, 1, 32'h40, 1, 0, 32'h1000);
    cycle("after_train", 1, 32'h40, 0, 32'h0, 0, 0, 32'h0);
    check("train_bcnt", branch_cnt, 32'd2);
    check("train_mcnt", mispred_cnt, 32'd2);
    cycle("no_valid", 0, 32'h40, 0, 32'h0, 0, 0, 32'h0);

    // Four not-taken updates: 11 -> 10 -> 01 -> 00, and the fourth stays at 00.
    for (int i = 0; i < 4; i++)
      cycle($sformatf("nt_%0d", i), 1, 32'h40, 1, 32'h40, 0, 1, 32'h0);
    cycle("after_nt", 1, 32'h40, 0, 32'h0, 0, 0, 32'h0);
    // From 00, one taken update gives 01. A wrap from 00 to 11 would predict taken.
    cycle("sat_lo_t", 1, 32'h40, 1, 32'h40, 1, 1, 32'h1000);
    cycle("sat_lo_chk", 1, 32'h40, 0, 32'h0, 0, 0, 32'h0);
    check("sat_lo_taken", {31'b0, predict_taken}, 32'd0);

    // A same-cycle lookup and update to 0x80 must show the old value first.
    cycle("same_cyc", 1, 32'h80, 1, 32'h80, 1, 0, 32'h300);
    cycle("same_next", 1, 32'h80, 0, 32'h0, 0, 0, 32'h0);
    cycle("misalign", 1, 32'h83, 0, 32'h0, 0, 0, 32'h0);

    // BTB allocation, then a tag miss on the same index. Without a BTB, the
    // second PC aliases onto the same counter.
    cycle("btb_upd", 1, 32'h100, 1, 32'h100, 1, 0, 32'h200);
    cycle("btb_hit", 1, 32'h100, 0, 32'h0, 0, 0, 32'h0);
    cycle("btb_alias", 1, 32'h100 + (32'd1 << (IDX_W + 2)), 0, 32'h0, 0, 0, 32'h0);
    cycle("btb_nt_keep", 1, 32'h100, 1, 32'h100, 0, 1, 32'h999);
    cycle("btb_nt_chk", 1, 32'h100, 0, 32'h0, 0, 0, 32'h0);

    // A short random mix to exercise several indices at once.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] lp;
      logic [31:0] upc;
      lp  = {$urandom_range(0, 3), $urandom_range(0, 7), 2'b00} << 2;
      upc = {$urandom_range(0, 3), $urandom_range(0, 7), 2'b00} << 2;
      cycle($sformatf("rnd_%0d", i), 1'($urandom_range(0, 1)), lp,
            1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom);
    end

    // Saturate 0x40 at 11, then assert reset while an update is presented.
    cycle("pre_rst_t0", 1, 32'h40, 1, 32'h40, 1, 0, 32'h1000);
    cycle("pre_rst_t1", 1, 32'h40, 1, 32'h40, 1, 0, 32'h1000);
    cycle("pre_rst_t2", 1, 32'h40, 1, 32'h40, 1, 0, 32'h1000);
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h40;
    update_valid  = 1'b1;
    update_pc     = 32'h40;
    update_taken  = 1'b1;
    update_pred   = 1'b0;
    #1 rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_taken",  {31'b0, predict_taken}, 32'd0);
    check("async_rst_hit",    {31'b0, predict_hit},   32'd0);
    check("async_rst_target", predict_target,         32'd0);
    check("async_rst_bcnt",   branch_cnt,             32'd0);
    check("async_rst_mcnt",   mispred_cnt,            32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_held_bcnt", branch_cnt, 32'd0);
    check("rst_held_taken", {31'b0, predict_taken}, 32'd0);
    update_valid = 1'b0;
    lookup_valid = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // After reset, the counters are 01 (one taken update flips the prediction)
    // and the BTB is empty.
    cycle("post_rst", 1, 32'h40, 0, 32'h0, 0, 0, 32'h0);
    cycle("post_rst_btb", 1, 32'h100, 0, 32'h0, 0, 0, 32'h0);
    cycle("post_rst_t", 1, 32'h40, 1, 32'h40, 1, 0, 32'h1000);
    cycle("post_rst_chk", 1, 32'h40, 0, 32'h0, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
